// File: rtl/lap_timer.sv
// Stopwatch/countdown core: HH:MM:SS.hh up/down counter with lap/preset slots.
// Optional AUTO_RELOAD_EN: on down-count expiry, reload the time from slot 0 if it is valid.
module lap_timer #(
  parameter int TICK_DIV  = 1250000,
  parameter int NUM_SLOTS = 3,
  parameter int SLOT_W    = 2,
  parameter int HOUR_MAX  = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 dir,
  input  logic                 clear,
  input  logic                 save,
  input  logic                 load,
  input  logic [SLOT_W-1:0]    slot,
  output logic [6:0]           hour,
  output logic [6:0]           minute,
  output logic [6:0]           second,
  output logic [6:0]           hundredth,
  output logic                 tick,
  output logic                 wrapped,
  output logic                 expired,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 running
);

  localparam int              PW    = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PLAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]      HMAX  = 7'(HOUR_MAX);

  logic [PW-1:0] presc;
  logic [27:0]   tim;
  logic [27:0]   mem [NUM_SLOTS];
  logic          run_q;
  logic          slot_ok;
  logic          do_load;
  logic          do_save;
  logic          count_en;
  logic [28:0]   up_res;
  logic [27:0]   dn_res;

  // Returns {wrap, next_time}; wrap is set only on the HOUR_MAX:59:59.99 rollover.
  function automatic logic [28:0] inc_time(input logic [27:0] t);
    logic [6:0] h, m, s, c;
    logic       w;
    {h, m, s, c} = t;
    w = 1'b0;
    if (c != 7'd99) c = c + 7'd1;
    else begin
      c = 7'd0;
      if (s != 7'd59) s = s + 7'd1;
      else begin
        s = 7'd0;
        if (m != 7'd59) m = m + 7'd1;
        else begin
          m = 7'd0;
          if (h != HMAX) h = h + 7'd1;
          else begin
            h = 7'd0;
            w = 1'b1;
          end
        end
      end
    end
    return {w, h, m, s, c};
  endfunction

  function automatic logic [27:0] dec_time(input logic [27:0] t);
    logic [6:0] h, m, s, c;
    {h, m, s, c} = t;
    if (c != 7'd0) c = c - 7'd1;
    else begin
      c = 7'd99;
      if (s != 7'd0) s = s - 7'd1;
      else begin
        s = 7'd59;
        if (m != 7'd0) m = m - 7'd1;
        else begin
          m = 7'd59;
          if (h != 7'd0) h = h - 7'd1;
          else h = HMAX;
        end
      end
    end
    return {h, m, s, c};
  endfunction

  assign slot_ok  = (32'(slot) < NUM_SLOTS);
  assign do_load  = load & ~clear & slot_ok;
  assign do_save  = save & ~load & ~clear & slot_ok;
  // Any control pulse, even an ignored one, freezes counting for that cycle.
  assign count_en = run_q & ~clear & ~load & ~save;
  assign up_res   = inc_time(tim);
  assign dn_res   = dec_time(tim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      presc      <= '0;
      tim        <= '0;
      tick       <= 1'b0;
      wrapped    <= 1'b0;
      expired    <= 1'b0;
      slot_valid <= '0;
    end else begin
      tick    <= 1'b0;
      wrapped <= 1'b0;
      expired <= 1'b0;
      run_q   <= run & ~save & ~load & ~clear;
      if (clear) begin
        tim   <= '0;
        presc <= '0;
      end else if (do_load) begin
        presc <= '0;
        tim   <= slot_valid[slot] ? mem[slot] : '0;
      end else if (do_save) begin
        slot_valid[slot] <= 1'b1;
      end else if (count_en) begin
        presc <= (presc == PLAST) ? '0 : presc + PW'(1);
        if (presc == PLAST) begin
          if (!dir) begin
            tim     <= up_res[27:0];
            tick    <= 1'b1;
            wrapped <= up_res[28];
          end else if (tim != '0) begin
            tim  <= dn_res;
            tick <= 1'b1;
            if (dn_res == '0) begin
              expired <= 1'b1;
`ifdef AUTO_RELOAD_EN
              if (slot_valid[0]) tim <= mem[0];
`endif
            end
          end
        end
      end
    end
  end

  // Slot storage carries no reset; slot_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (do_save) mem[slot] <= tim;
  end

  assign {hour, minute, second, hundredth} = tim;
  assign running = run_q;

endmodule

// File: tb/tb_lap_timer.sv
// Self-checking bench for lap_timer: hundredths-count model plus directed scenarios.
module tb_lap_timer;
  localparam int TD   = 4;
  localparam int NS   = 3;
  localparam int SW   = 2;
  localparam int HM   = 23;
  localparam int MAXT = (HM + 1) * 360000;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, dir = 1'b0;
  logic clear = 1'b0, save = 1'b0, load = 1'b0;
  logic [SW-1:0] slot = '0;
  logic [6:0] hour, minute, second, hundredth;
  logic tick, wrapped, expired, running;
  logic [NS-1:0] slot_valid;

  lap_timer #(.TICK_DIV(TD), .NUM_SLOTS(NS), .SLOT_W(SW), .HOUR_MAX(HM)) dut (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .clear(clear), .save(save),
    .load(load), .slot(slot), .hour(hour), .minute(minute), .second(second),
    .hundredth(hundredth), .tick(tick), .wrapped(wrapped), .expired(expired),
    .slot_valid(slot_valid), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit skip = 1'b0;
  int inject = -1;
  logic [27:0] force_val;

  // Model state: time as a single count of hundredths since 00:00:00.00.
  int m_total = 0, m_presc = 0;
  bit m_runq = 0, m_tick = 0, m_wrap = 0, m_exp = 0;
  int m_slot [NS];
  bit [NS-1:0] m_valid = '0;

  function automatic logic [27:0] fields(input int t);
    return {7'(t / 360000), 7'((t / 6000) % 60), 7'((t / 100) % 60), 7'(t % 100)};
  endfunction

  function automatic int tot();
    return int'(hour) * 360000 + int'(minute) * 6000 + int'(second) * 100 + int'(hundredth);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int s;
    bit prev;
    if (reset) begin
      m_total = 0; m_presc = 0; m_runq = 0;
      m_tick = 0; m_wrap = 0; m_exp = 0; m_valid = '0;
    end else begin
      s = int'(slot);
      m_tick = 0; m_wrap = 0; m_exp = 0;
      prev = m_runq;
      m_runq = run && !save && !load && !clear;
      if (clear) begin
        m_total = 0; m_presc = 0;
      end else if (load && s < NS) begin
        m_total = m_valid[s] ? m_slot[s] : 0;
        m_presc = 0;
      end else if (save && !load && s < NS) begin
        m_slot[s] = (inject >= 0) ? inject : m_total;
        m_valid[s] = 1'b1;
      end else if (!load && !save && prev) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          if (!dir) begin
            m_total = (m_total + 1) % MAXT;
            m_tick = 1;
            m_wrap = (m_total == 0);
          end else if (m_total > 0) begin
            m_total = m_total - 1;
            m_tick = 1;
            m_exp = (m_total == 0);
`ifdef AUTO_RELOAD_EN
            if (m_exp && m_valid[0]) m_total = m_slot[0];
`endif
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  end

  logic [34:0] act_v, exp_v;
  always @(posedge clk) begin
    #2;
    if (!skip) begin
      act_v = {hour, minute, second, hundredth, tick, wrapped, expired, slot_valid, running};
      exp_v = {fields(m_total), m_tick, m_wrap, m_exp, m_valid, m_runq};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n, output int cyc);
    int cnt;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < n * TD + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (tick) cnt++;
    end
    if (cnt < n) chk("tick_timeout", cnt, n);
  endtask

  task automatic pulse_load(input int s);
    @(negedge clk); slot = SW'(s); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic pulse_save(input int s);
    @(negedge clk); slot = SW'(s); save = 1'b1;
    @(negedge clk); save = 1'b0;
  endtask

  // Deposit an arbitrary time into a slot, then clear the live time.
  task automatic preset(input int s, input int t);
    @(negedge clk);
    skip = 1'b1;
    force_val = fields(t);
    force dut.tim = force_val;
    inject = t; slot = SW'(s); save = 1'b1;
    @(negedge clk);
    release dut.tim;
    save = 1'b0; inject = -1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; skip = 1'b0;
  endtask

  initial begin
    int cyc, n;
    repeat (2) @(negedge clk);
    chk("reset_time", tot(), 0);
    chk("reset_valid", int'(slot_valid), 0);
    chk("reset_running", int'(running), 0);
    reset = 1'b0; run = 1'b1;

    // Scenario 1: count up
    wait_ticks(1, cyc);
    chk("first_tick_latency", cyc, 5);
    chk("first_hundredth", int'(hundredth), 1);
    wait_ticks(99, cyc);
    chk("second_after_100", int'(second), 1);
    chk("hundredth_after_100", int'(hundredth), 0);
    @(negedge clk); run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    wait_ticks(2, cyc);

    // Scenario 2: wrap from the last legal time
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    preset(0, MAXT - 1);
    pulse_load(0);
    chk("preset_loaded", tot(), MAXT - 1);
    run = 1'b1; dir = 1'b0;
    wait_ticks(1, cyc);
    chk("wrap_time", tot(), 0);
    chk("wrap_pulse", int'(wrapped), 1);
    @(posedge clk); #1;
    chk("wrap_one_cycle", int'(wrapped), 0);

    // Scenario 3: count down to expiry
    @(negedge clk); run = 1'b0;
    preset(0, 100);
    run = 1'b1;
    wait_ticks(2, cyc);
    @(negedge clk); run = 1'b0;
    pulse_save(2);
    pulse_load(2);
    chk("preload_02", tot(), 2);
    dir = 1'b1; run = 1'b1;
    wait_ticks(1, cyc);
    chk("down_01", tot(), 1);
    chk("no_early_expiry", int'(expired), 0);
    wait_ticks(1, cyc);
    chk("expired_pulse", int'(expired), 1);
`ifdef AUTO_RELOAD_EN
    chk("reload_value", tot(), 100);
    wait_ticks(1, cyc);
    chk("reload_continues", tot(), 99);
`else
    chk("down_00", tot(), 0);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (tick || expired) n++;
    end
    chk("held_zero_quiet", n, 0);
    chk("held_zero_time", tot(), 0);
`endif

    // Scenario 4: save, then simultaneous load+save
    @(negedge clk); reset = 1'b1; run = 1'b0; dir = 1'b0;
    @(negedge clk); reset = 1'b0;
    chk("valid_after_reset", int'(slot_valid), 0);
    run = 1'b1;
    wait_ticks(345, cyc);
    chk("count_345", tot(), 345);
    @(negedge clk); run = 1'b0;
    pulse_save(1);
    @(negedge clk); slot = 2'd2; load = 1'b1; save = 1'b1;
    @(negedge clk); load = 1'b0; save = 1'b0;
    chk("valid_010", int'(slot_valid), 2);
    chk("dual_load_invalid", tot(), 0);

    // Scenario 5: load valid then invalid slot
    pulse_load(1);
    chk("load_slot1", tot(), 345);
    pulse_load(2);
    chk("load_invalid_slot2", tot(), 0);

    // Scenario 6: out-of-range slot
    pulse_load(1);
    pulse_save(3);
    chk("slot3_save_ignored", int'(slot_valid), 2);
    pulse_load(3);
    chk("slot3_load_ignored", tot(), 345);

    // Scenario 7: clear, then asynchronous reset right after a tick
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_time", tot(), 0);
    run = 1'b1;
    wait_ticks(3, cyc);
    reset = 1'b1;
    #1;
    chk("async_reset_tick", int'(tick), 0);
    chk("async_reset_time", tot(), 0);
    chk("async_reset_valid", int'(slot_valid), 0);
    chk("async_reset_running", int'(running), 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    wait_ticks(1, cyc);
    chk("restart_latency", cyc, 5);
    chk("restart_hundredth", int'(hundredth), 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
